// File: rtl/pmc_dc_ser_pkg.sv
// Shared types and default sizing for the PMC digital-configuration chain serializer.
// Optional readback compare is enabled with PMC_DC_SER_READBACK_EN.
package pmc_dc_ser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD
    } pmc_dc_ser_state_t;

    localparam int RES_W_DEF      = 2;
    localparam int TH_W_DEF       = 6;
    localparam int NUM_PIXELS_DEF = 4;
    localparam int CLK_DIV_DEF    = 2;

    // Bit order on the chain follows this packing: res in the MSBs, th below.
    typedef struct packed {
        logic [RES_W_DEF-1:0] res;
        logic [TH_W_DEF-1:0]  th;
    } pmc_dc_cfg_t;

endpackage

// File: rtl/pmc_dc_ser_clkgen.sv
// Half-period tick generator: phase_end_o marks the last cycle of each CLK_DIV-long phase.
// The count restarts whenever the owning FSM changes state (or idles).
module pmc_dc_ser_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic phase_end_o
);

    localparam int CW = $clog2(CLK_DIV) + 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign cnt_d       = restart_i ? '0 : cnt_q + 1'b1;
    assign phase_end_o = (cnt_q == CW'(CLK_DIV - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pmc_dc_serializer.sv
// Pushes {res,th} into the pixel configuration chain once per pixel, then strobes sload.
// Retransfers on any input change and once after reset; PMC_DC_SER_READBACK_EN adds sdi compare.
module pmc_dc_serializer
    import pmc_dc_ser_pkg::*;
#(
    parameter int RES_W      = RES_W_DEF,
    parameter int TH_W       = TH_W_DEF,
    parameter int NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int CLK_DIV    = CLK_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RES_W-1:0] res,
    input  logic [TH_W-1:0]  th,
    output logic             sck,
    output logic             sdo,
    output logic             sload,
    output logic             busy,
    output logic             done
`ifdef PMC_DC_SER_READBACK_EN
    ,
    input  logic             sdi,
    output logic             err
`endif
);

    localparam int CFG_W = RES_W + TH_W;
    localparam int TOTAL = CFG_W * NUM_PIXELS;
    localparam int BW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int PW    = (CFG_W > 1) ? $clog2(CFG_W) : 1;

    pmc_dc_ser_state_t state_q, state_d;
    logic [CFG_W-1:0]  cfg_in, shadow_q;
    logic [BW-1:0]     bit_cnt_q;
    logic [PW-1:0]     pbit_q, pbit_nxt;
    logic              force_q;
    logic              sck_q, sdo_q, sload_q, busy_q, done_q;
    logic              phase_end, trigger, last_bit, restart;

    assign cfg_in   = {res, th};
    assign trigger  = force_q || (cfg_in != shadow_q);
    assign last_bit = (bit_cnt_q == BW'(TOTAL - 1));
    // pbit tracks bit_cnt mod CFG_W without a divider
    assign pbit_nxt = (pbit_q == PW'(CFG_W - 1)) ? '0 : pbit_q + 1'b1;
    assign restart  = (state_d != state_q) || (state_q == IDLE);

    pmc_dc_ser_clkgen #(
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .clk_i      (clk),
        .rst_i      (rst),
        .restart_i  (restart),
        .phase_end_o(phase_end)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (trigger)   state_d = SHIFT_LO;
            SHIFT_LO: if (phase_end) state_d = SHIFT_HI;
            SHIFT_HI: if (phase_end) state_d = last_bit ? LOAD : SHIFT_LO;
            LOAD:     if (phase_end) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            force_q   <= 1'b1;
            bit_cnt_q <= '0;
            pbit_q    <= '0;
            sck_q     <= 1'b0;
            sdo_q     <= 1'b0;
            sload_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: if (trigger) begin
                    shadow_q  <= cfg_in;
                    force_q   <= 1'b0;
                    busy_q    <= 1'b1;
                    bit_cnt_q <= '0;
                    pbit_q    <= '0;
                    sck_q     <= 1'b0;
                    sdo_q     <= cfg_in[CFG_W-1];
                end
                SHIFT_LO: if (phase_end) sck_q <= 1'b1;
                SHIFT_HI: if (phase_end) begin
                    sck_q <= 1'b0;
                    if (last_bit) begin
                        sload_q   <= 1'b1;
                        bit_cnt_q <= '0;
                        pbit_q    <= '0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        pbit_q    <= pbit_nxt;
                        sdo_q     <= shadow_q[PW'(CFG_W - 1) - pbit_nxt];
                    end
                end
                LOAD: if (phase_end) begin
                    sload_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sck   = sck_q;
    assign sdo   = sdo_q;
    assign sload = sload_q;
    assign busy  = busy_q;
    assign done  = done_q;

`ifdef PMC_DC_SER_READBACK_EN
    // The chain returns what the previous transfer loaded, in the same order it was sent.
    logic [CFG_W-1:0] prev_q;
    logic             chk_q, mis_q, err_q, bit_bad;

    assign bit_bad = (sdi != prev_q[PW'(CFG_W - 1) - pbit_q]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            chk_q  <= 1'b0;
            mis_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (trigger) begin
                    prev_q <= shadow_q;
                    chk_q  <= !force_q;
                    mis_q  <= 1'b0;
                end
                SHIFT_HI: if (phase_end) begin
                    mis_q <= mis_q | bit_bad;
                    if (last_bit && chk_q && (mis_q || bit_bad)) err_q <= 1'b1;
                end
                LOAD: if (phase_end && chk_q && !mis_q) err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign err = err_q;
`endif

endmodule
